// File: rtl/multi_level_pkg.sv
// Shared types and helpers for the multi-level pipeline sequencing controller.
package multi_level_pkg;

    localparam int unsigned DEFAULT_STAGES = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StFlush = 2'd3
    } ctrl_state_e;

    // Number of set bits; callers zero-extend narrower vectors.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_level_slot.sv
// One pipeline level: tracks its valid bit, forms its ready term and load enable.
module multi_level_slot (
    input  logic clk,
    input  logic rst_n,
    input  logic src_vld,
    input  logic rdy_next,
    input  logic flush,
    output logic vld,
    output logic rdy,
    output logic en
);

    logic vld_q;

    // A level can take new data when empty or when its contents move on this cycle.
    assign rdy = !vld_q || rdy_next;
    assign en  = rdy && src_vld && !flush;
    assign vld = vld_q;

    // Valid bit: set on load, cleared when contents leave, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (en) begin
            vld_q <= 1'b1;
        end else if (rdy) begin
            vld_q <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_level_seq_ctrl.sv
// Valid/ready sequencer for the registered AND-reduce pipeline: per-level enables,
// bubble-collapsing backpressure, drain/flush control and accept/retire counters.
module multi_level_seq_ctrl
    import multi_level_pkg::*;
#(
    parameter int unsigned STAGES = DEFAULT_STAGES,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         out_ready,
    output logic                         out_valid,
    input  logic                         drain_req,
    input  logic                         flush,
    output logic [STAGES-1:0]            stage_en,
    output logic [STAGES-1:0]            stage_vld,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic                         drain_done,
    output logic [1:0]                   state,
    output logic [CNT_W-1:0]             accepted_cnt,
    output logic [CNT_W-1:0]             retired_cnt
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    ctrl_state_e       state_q;
    logic              drain_done_q;
    logic [CNT_W-1:0]  accepted_q;
    logic [CNT_W-1:0]  retired_q;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] en;
    logic [STAGES-1:0] vld_nxt;
    logic              accept_ok;
    logic              in_fire;
    logic              retire;

    // Ready ripples back from the output; each level's local signals keep the chain acyclic.
    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic src_vld;
        logic rdy_next;
        logic rdy_l;

        if (i == 0) begin : g_head
            assign src_vld = in_fire;
        end else begin : g_body
            assign src_vld = vld[i-1];
        end

        if (i == STAGES - 1) begin : g_tail
            assign rdy_next = out_ready;
        end else begin : g_link
            assign rdy_next = g_slot[i+1].rdy_l;
        end

        multi_level_slot u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .src_vld  (src_vld),
            .rdy_next (rdy_next),
            .flush    (flush),
            .vld      (vld[i]),
            .rdy      (rdy_l),
            .en       (en[i])
        );

        assign rdy[i] = rdy_l;
    end

    // Handshake qualification: flush and drain requests block acceptance in their own cycle.
    always_comb begin
        accept_ok = ((state_q == StIdle) || (state_q == StRun)) && !flush && !drain_req;
        in_ready  = accept_ok && rdy[0];
        in_fire   = in_valid && in_ready;
        retire    = vld[STAGES-1] && out_ready && !flush;
    end

    // Look-ahead of the valid vector, used to detect an emptying pipeline.
    always_comb begin
        vld_nxt = '0;
        for (int i = 0; i < STAGES; i++) begin
            vld_nxt[i] = !flush && (en[i] || (vld[i] && !rdy[i]));
        end
    end

    // Control FSM with the registered drain-complete pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            drain_done_q <= 1'b0;
        end else begin
            drain_done_q <= 1'b0;
            if (flush) begin
                state_q <= StFlush;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (drain_req) begin
                            drain_done_q <= 1'b1;
                        end else if (in_fire) begin
                            state_q <= StRun;
                        end
                    end
                    StRun: begin
                        if (drain_req) begin
                            state_q <= StDrain;
                        end else if (vld_nxt == '0) begin
                            state_q <= StIdle;
                        end
                    end
                    StDrain: begin
                        if (vld_nxt == '0) begin
                            state_q      <= StIdle;
                            drain_done_q <= 1'b1;
                        end
                    end
                    StFlush: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // Wrap-around accept/retire counters; their difference is the in-flight or discard count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accepted_q <= '0;
            retired_q  <= '0;
        end else begin
            if (in_fire) begin
                accepted_q <= accepted_q + CNT_W'(1);
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign stage_en     = en;
    assign stage_vld    = vld;
    assign out_valid    = vld[STAGES-1];
    assign occupancy    = OCC_W'(popcount(32'(vld)));
    assign drain_done   = drain_done_q;
    assign state        = state_q;
    assign accepted_cnt = accepted_q;
    assign retired_cnt  = retired_q;

endmodule
